// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
// Holds FSM states, side ids and the latched request bundle.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    logic        rd;
    logic        wr;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of instr port, data port and shared bus signals.
// slave = arbiter view, master = requester/memory model view.
interface mem_arbiter_if;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mbe;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata, d_mbe,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata, d_mbe,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_arbiter_req_latch.sv
// Register bank holding the granted request for a transaction.
// Ports: clk/rst, load + side select, both request inputs, q out.
module arb_req_latch
  import arbiter_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  arb_side_t   sel,
  input  logic [31:0] i_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_mbe,
  output arb_req_t    q
);

  arb_req_t nxt;

  always_comb begin
    nxt = '0;
    if (sel == SIDE_D) begin
      nxt.addr  = d_addr;
      nxt.wdata = d_wdata;
      nxt.mbe   = d_mbe;
      nxt.wr    = d_write;
      // store wins when both strobes are set
      nxt.rd    = d_read & ~d_write;
    end else begin
      nxt.addr  = i_addr;
      nxt.rd    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (load) q <= nxt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter merging instr fetch and data ports onto one memory bus.
// Ports: clk, rst, bus (mem_arbiter_if.slave); FAIR selects policy.
module mem_arbiter
  import arbiter_types::*;
#(
  parameter bit FAIR = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_t state_q, state_d;
  arb_side_t  last_q;
  arb_req_t   req_q;
  logic       d_req;
  logic       grant_i, grant_d;
  logic       idle;
  logic [31:0] i_rdata_q, d_rdata_q;

  assign idle  = (state_q == IDLE);
  assign d_req = bus.d_read | bus.d_write;

  // I wins only when D is absent, or fair mode and D went last
  assign grant_i = idle & bus.i_read &
                   (~d_req | (FAIR & (last_q == SIDE_D)));
  assign grant_d = idle & d_req & ~grant_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i) state_d = SERVE_I;
        else if (grant_d) state_d = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SIDE_I;
    end else begin
      state_q <= state_d;
      if (grant_i) last_q <= SIDE_I;
      else if (grant_d) last_q <= SIDE_D;
    end
  end

  arb_req_latch u_latch (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_i | grant_d),
    .sel     (grant_d ? SIDE_D : SIDE_I),
    .i_addr  (bus.i_addr),
    .d_read  (bus.d_read),
    .d_write (bus.d_write),
    .d_addr  (bus.d_addr),
    .d_wdata (bus.d_wdata),
    .d_mbe   (bus.d_mbe),
    .q       (req_q)
  );

  assign bus.mem_read  = ~idle & req_q.rd;
  assign bus.mem_write = ~idle & req_q.wr;
  assign bus.mem_mbe   = idle ? 4'b0 : req_q.mbe;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;

  assign bus.i_resp = (state_q == SERVE_I) & bus.mem_resp;
  assign bus.d_resp = (state_q == SERVE_D) & bus.mem_resp;

  // read data passes through in the resp cycle, then is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (bus.i_resp) i_rdata_q <= bus.mem_rdata;
      if (bus.d_resp) d_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.i_rdata = bus.i_resp ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata = bus.d_resp ? bus.mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table on a FAIR=1 instance,
// hand sequence on a FAIR=0 instance.
module tb_mem_arbiter;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dmbe;
    logic [31:0] mrd;
    logic        mresp;
    logic        mr;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [3:0]  mbe;
    logic        iresp;
    logic [31:0] ird;
    logic        dresp;
    logic [31:0] drd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  vec_t v[$];

  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter_if bus0();

  mem_arbiter #(.FAIR(1'b1)) u_fair (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_arbiter #(.FAIR(1'b0)) u_prio (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  function automatic vec_t mk(
    logic rst_i, logic ir, logic [31:0] ia,
    logic dr, logic dw, logic [31:0] da,
    logic [31:0] dwd, logic [3:0] dmbe,
    logic [31:0] mrd, logic mresp,
    logic mr, logic mw, logic [31:0] ma,
    logic [31:0] mwd, logic [3:0] mbe,
    logic iresp, logic [31:0] ird,
    logic dresp, logic [31:0] drd);
    vec_t r;
    r.rst = rst_i; r.ir = ir; r.ia = ia;
    r.dr = dr; r.dw = dw; r.da = da;
    r.dwd = dwd; r.dmbe = dmbe;
    r.mrd = mrd; r.mresp = mresp;
    r.mr = mr; r.mw = mw; r.ma = ma;
    r.mwd = mwd; r.mbe = mbe;
    r.iresp = iresp; r.ird = ird;
    r.dresp = dresp; r.drd = drd;
    return r;
  endfunction

  task automatic chk(string name, int idx,
                     logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h",
               name, idx, got, exp);
    end
  endtask

  task automatic step0(int idx, logic ir, logic dr,
                       logic mresp, logic mr, logic [31:0] ma,
                       logic iresp, logic dresp);
    @(negedge clk);
    bus0.i_read   = ir;
    bus0.d_read   = dr;
    bus0.mem_resp = mresp;
    #1;
    chk("prio_mem_read", idx, 32'(bus0.mem_read), 32'(mr));
    chk("prio_mem_addr", idx, bus0.mem_addr, ma);
    chk("prio_i_resp", idx, 32'(bus0.i_resp), 32'(iresp));
    chk("prio_d_resp", idx, 32'(bus0.d_resp), 32'(dresp));
  endtask

  initial begin
    bus.i_read = 0; bus.i_addr = 0;
    bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.d_mbe = 0;
    bus.mem_rdata = 0; bus.mem_resp = 0;
    bus0.i_read = 0; bus0.i_addr = 32'h600;
    bus0.d_read = 0; bus0.d_write = 0;
    bus0.d_addr = 32'h500; bus0.d_wdata = 0; bus0.d_mbe = 0;
    bus0.mem_rdata = 0; bus0.mem_resp = 0;

    // reset, single instruction fetch, spurious resp
    v.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    v.push_back(mk(0,1,'h60,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    v.push_back(mk(0,0,'h99,0,0,0,0,0,0,0, 1,0,'h60,0,0,0,0,0,0));
    v.push_back(mk(0,0,'h99,0,0,0,0,0,0,0, 1,0,'h60,0,0,0,0,0,0));
    v.push_back(mk(0,0,'h99,0,0,0,0,0,'h00A00093,1,
                   1,0,'h60,0,0,1,'h00A00093,0,0));
    v.push_back(mk(0,0,0,0,0,0,0,0,'h12345678,0,
                   0,0,'h60,0,0,0,'h00A00093,0,0));
    v.push_back(mk(0,0,0,0,0,0,0,0,'hDEAD,1,
                   0,0,'h60,0,0,0,'h00A00093,0,0));
    // store, inputs changed after grant
    v.push_back(mk(0,0,0,0,1,'h104,'hAB00,'h2,0,0,
                   0,0,'h60,0,0,0,'h00A00093,0,0));
    v.push_back(mk(0,0,0,1,0,'h200,'hFFFF,'hF,0,0,
                   0,1,'h104,'hAB00,'h2,0,'h00A00093,0,0));
    v.push_back(mk(0,0,0,0,0,0,0,0,0,0,
                   0,1,'h104,'hAB00,'h2,0,'h00A00093,0,0));
    v.push_back(mk(0,0,0,0,0,0,0,0,'h55,1,
                   0,1,'h104,'hAB00,'h2,0,'h00A00093,1,'h55));
    v.push_back(mk(0,0,0,0,0,0,0,0,0,0,
                   0,0,'h104,'hAB00,0,0,'h00A00093,0,'h55));
    // read+write together, then reset mid-transaction
    v.push_back(mk(0,0,0,1,1,'h108,'h11223344,'hF,0,0,
                   0,0,'h104,'hAB00,0,0,'h00A00093,0,'h55));
    v.push_back(mk(0,0,0,1,1,'h108,'h11223344,'hF,0,0,
                   0,1,'h108,'h11223344,'hF,0,'h00A00093,0,'h55));
    v.push_back(mk(1,0,0,1,1,'h108,'h11223344,'hF,0,0,
                   0,0,0,0,0,0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0,0,0,'h77,1, 0,0,0,0,0,0,0,0,0));
    // both held, fair: D, I, D, I
    v.push_back(mk(0,1,'h300,1,0,'h400,0,0,0,0,
                   0,0,0,0,0,0,0,0,0));
    v.push_back(mk(0,1,'h300,1,0,'h400,0,0,'hD1,1,
                   1,0,'h400,0,0,0,0,1,'hD1));
    v.push_back(mk(0,1,'h300,1,0,'h400,0,0,0,0,
                   0,0,'h400,0,0,0,0,0,'hD1));
    v.push_back(mk(0,1,'h300,1,0,'h400,0,0,'h11,1,
                   1,0,'h300,0,0,1,'h11,0,'hD1));
    v.push_back(mk(0,1,'h300,1,0,'h400,0,0,0,0,
                   0,0,'h300,0,0,0,'h11,0,'hD1));
    v.push_back(mk(0,1,'h300,1,0,'h400,0,0,'hD2,1,
                   1,0,'h400,0,0,0,'h11,1,'hD2));
    v.push_back(mk(0,1,'h300,1,0,'h400,0,0,0,0,
                   0,0,'h400,0,0,0,'h11,0,'hD2));
    v.push_back(mk(0,1,'h300,1,0,'h400,0,0,'h22,1,
                   1,0,'h300,0,0,1,'h22,0,'hD2));
    v.push_back(mk(0,0,0,0,0,0,0,0,0,0,
                   0,0,'h300,0,0,0,'h22,0,'hD2));

    for (int k = 0; k < v.size(); k++) begin
      @(negedge clk);
      rst           = v[k].rst;
      bus.i_read    = v[k].ir;
      bus.i_addr    = v[k].ia;
      bus.d_read    = v[k].dr;
      bus.d_write   = v[k].dw;
      bus.d_addr    = v[k].da;
      bus.d_wdata   = v[k].dwd;
      bus.d_mbe     = v[k].dmbe;
      bus.mem_rdata = v[k].mrd;
      bus.mem_resp  = v[k].mresp;
      #1;
      chk("mem_read", k, 32'(bus.mem_read), 32'(v[k].mr));
      chk("mem_write", k, 32'(bus.mem_write), 32'(v[k].mw));
      chk("mem_addr", k, bus.mem_addr, v[k].ma);
      chk("mem_wdata", k, bus.mem_wdata, v[k].mwd);
      chk("mem_mbe", k, 32'(bus.mem_mbe), 32'(v[k].mbe));
      chk("i_resp", k, 32'(bus.i_resp), 32'(v[k].iresp));
      chk("i_rdata", k, bus.i_rdata, v[k].ird);
      chk("d_resp", k, 32'(bus.d_resp), 32'(v[k].dresp));
      chk("d_rdata", k, bus.d_rdata, v[k].drd);
    end

    // priority mode: D keeps winning until d_read drops
    step0(0, 1, 1, 0, 0, 32'h0,   0, 0);
    step0(1, 1, 1, 1, 1, 32'h500, 0, 1);
    step0(2, 1, 1, 0, 0, 32'h500, 0, 0);
    step0(3, 1, 1, 1, 1, 32'h500, 0, 1);
    step0(4, 1, 0, 0, 0, 32'h500, 0, 0);
    step0(5, 1, 0, 1, 1, 32'h600, 1, 0);
    step0(6, 0, 0, 0, 0, 32'h600, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
